// File: rtl/sume_pkg.sv
// sume_pkg: shared state type, digit limit and output width for the decimal adder.
package sume_pkg;
   localparam int W = 12;
   localparam int DIGIT_MAX = 9;
   typedef enum logic [2:0] {W1_C, W1_D, W1_U, W2_C, W2_D, W2_U, SUM, DONE} state_t;
   function automatic logic is_digit(logic [3:0] s);
      return s <= 4'(DIGIT_MAX);
   endfunction
endpackage

// File: rtl/sume_if.sv
// sume_if: control/result link between the FSM and one decimal accumulator.
interface sume_if;
   import sume_pkg::*;
   logic ld;
   logic clr;
   logic [3:0] digit;
   logic [W-1:0] acc;
   modport master(output ld, clr, digit, input acc);
   modport slave(input ld, clr, digit, output acc);
endinterface

// File: rtl/sume_dec_acc.sv
// sume_dec_acc: register that shifts in one decimal digit per load (acc*10 + digit), sync clear.
module sume_dec_acc
   import sume_pkg::*;
(
   input logic clk,
   sume_if.slave a
);
   logic [W-1:0] acc_d, acc_q;
   always_comb acc_d = a.clr ? '0 : a.ld ? W'(acc_q * W'(10) + W'(a.digit)) : acc_q;
   always_ff @(posedge clk) acc_q <= acc_d;
   assign a.acc = acc_q;
endmodule

// File: rtl/sume.sv
// sume: captures two 3-digit decimal operands MSD first, then registers their binary sum.
module sume
   import sume_pkg::*;
(
   input  logic         clk,
   input  logic         n_reset,
   input  logic [3:0]   sample,
   output logic [W-1:0] w1,
   output logic [W-1:0] w2,
   output logic [W-1:0] cdu
);
   sume_if a1 ();
   sume_if a2 ();
   sume_dec_acc u_w1 (.clk(clk), .a(a1.slave));
   sume_dec_acc u_w2 (.clk(clk), .a(a2.slave));
   state_t state_d, state_q;
   logic [W-1:0] cdu_d, cdu_q;
   logic in_w1, in_w2, ok;
   always_comb begin
      in_w1 = state_q inside {W1_C, W1_D, W1_U};
      in_w2 = state_q inside {W2_C, W2_D, W2_U};
      ok = is_digit(sample) && (in_w1 || in_w2);
      state_d = state_q == SUM ? DONE : ok ? state_t'(state_q + 3'd1) : state_q;
      cdu_d = state_q == SUM ? a1.acc + a2.acc : cdu_q;
      a1.ld = ok && in_w1;
      a2.ld = ok && in_w2;
      a1.clr = n_reset;
      a2.clr = n_reset;
      a1.digit = sample;
      a2.digit = sample;
   end
   // n_reset is active-high despite its name
   always_ff @(posedge clk) begin
      if (n_reset) begin
         state_q <= W1_C;
         cdu_q <= '0;
      end else begin
         state_q <= state_d;
         cdu_q <= cdu_d;
      end
   end
   assign w1 = a1.acc;
   assign w2 = a2.acc;
   assign cdu = cdu_q;
endmodule

// File: tb/tb_sume.sv
// tb_sume: table-driven directed vectors for sume, plus a DONE-hold sequence.
module tb_sume;
   import sume_pkg::*;
   logic clk = 0;
   logic n_reset = 1;
   logic [3:0] sample = 0;
   logic [W-1:0] w1, w2, cdu;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic r;
      logic [3:0] s;
      int e1;
      int e2;
      int e3;
   } vec_t;
   vec_t v[$];
   always #5 clk = ~clk;
   sume dut (.clk(clk), .n_reset(n_reset), .sample(sample), .w1(w1), .w2(w2), .cdu(cdu));
   task automatic add(input logic r, input logic [3:0] s, input int e1, input int e2, input int e3);
      vec_t t;
      t.r = r; t.s = s; t.e1 = e1; t.e2 = e2; t.e3 = e3;
      v.push_back(t);
   endtask
   task automatic chk(input string n, input int idx, input logic [W-1:0] got, input int exp);
      checks++;
      if (got !== W'(exp)) begin
         errors++;
         $display("FAIL %s step %0d got %0d exp %0d", n, idx, got, exp);
      end
   endtask
   task automatic step(input logic r, input logic [3:0] s);
      n_reset = r;
      sample = s;
      @(posedge clk);
      #1;
   endtask
   initial begin
      add(1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0); add(0, 2, 12, 0, 0); add(0, 3, 123, 0, 0);
      add(0, 4, 123, 4, 0); add(0, 5, 123, 45, 0); add(0, 6, 123, 456, 0);
      add(0, 0, 123, 456, 579); add(0, 9, 123, 456, 579);
      add(1, 9, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 9, i < 3 ? (i == 0 ? 9 : i == 1 ? 99 : 999) : 999,
                                      i < 3 ? 0 : (i == 3 ? 9 : i == 4 ? 99 : 999), 0);
      add(0, 0, 999, 999, 1998);
      add(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0);
      add(0, 5, 0, 0, 0);
      add(1, 0, 0, 0, 0);
      add(0, 4'hF, 0, 0, 0);
      add(0, 1, 1, 0, 0); add(0, 4'hA, 1, 0, 0); add(0, 2, 12, 0, 0); add(0, 3, 123, 0, 0);
      add(0, 4, 123, 4, 0); add(0, 4'hC, 123, 4, 0); add(0, 5, 123, 45, 0); add(0, 6, 123, 456, 0);
      add(0, 0, 123, 456, 579);
      add(1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0); add(0, 2, 12, 0, 0); add(0, 3, 123, 0, 0);
      add(0, 4, 123, 4, 0); add(0, 5, 123, 45, 0); add(0, 6, 123, 456, 0);
      add(1, 0, 0, 0, 0);
      add(0, 7, 7, 0, 0); add(0, 8, 78, 0, 0);
      add(1, 9, 0, 0, 0);
      add(0, 1, 1, 0, 0); add(0, 2, 12, 0, 0); add(0, 3, 123, 0, 0);
      add(0, 4, 123, 4, 0); add(0, 5, 123, 45, 0); add(0, 6, 123, 456, 0);
      add(0, 0, 123, 456, 579);
      @(negedge clk);
      foreach (v[i]) begin
         step(v[i].r, v[i].s);
         chk("w1", i, w1, v[i].e1);
         chk("w2", i, w2, v[i].e2);
         chk("cdu", i, cdu, v[i].e3);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 9);
         chk("done_w1", i, w1, 123);
         chk("done_w2", i, w2, 456);
         chk("done_cdu", i, cdu, 579);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sume.md
SUME -- requirements
Module: sume

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port n_reset, input, 1 bit: synchronous, active-high reset; asserted when n_reset = 1, despite the name.
REQ-003 The block SHALL have port sample, input, 4 bits: one decimal digit per clock, unsigned.
REQ-004 The block SHALL have port w1, output, 12 bits: first operand, unsigned binary, range 0..999.
REQ-005 The block SHALL have port w2, output, 12 bits: second operand, unsigned binary, range 0..999.
REQ-006 The block SHALL have port cdu, output, 12 bits: unsigned binary sum w1+w2, range 0..1998.

Function
REQ-007 The block SHALL implement an FSM with states W1_C, W1_D, W1_U, W2_C, W2_D, W2_U, SUM and DONE.
REQ-008 The block SHALL leave reset in W1_C.
REQ-009 In each digit state, on a rising edge with sample <= 9, the block SHALL update the selected operand as operand <= operand*10 + sample and advance to the next state.
REQ-010 The state order SHALL be W1_C -> W1_D -> W1_U -> W2_C -> W2_D -> W2_U -> SUM.
REQ-011 In a digit state, a sample value of 10..15 SHALL be ignored: operand unchanged, state unchanged (stall).
REQ-012 W1_C/W1_D/W1_U SHALL write w1 only; W2_C/W2_D/W2_U SHALL write w2 only.
REQ-013 The most-significant digit SHALL be entered first.
REQ-014 In SUM, on the next rising edge, the block SHALL register cdu <= w1 + w2 and go to DONE; sample is ignored in SUM (0 is the conventional trigger value, not required).
REQ-015 cdu SHALL be valid one clock after the last digit is captured; total latency from the first digit edge to valid cdu is 7 rising edges.
REQ-016 In DONE, w1, w2 and cdu SHALL hold their values and sample SHALL be ignored until reset.
REQ-017 w1 and w2 SHALL update visibly after each digit capture (partial values, e.g. 1, 12, 123).
REQ-018 cdu SHALL remain 0 until SUM executes.
REQ-019 The arithmetic width rule SHALL be: operands at most 999 (10 bits needed), sum at most 1998 (11 bits), zero-extended to 12 bits, with no overflow possible.
REQ-020 All outputs SHALL be registered, with no combinational path from sample to outputs.

Reset
REQ-021 While n_reset = 1 at a rising edge, the block SHALL set state = W1_C and w1 = w2 = cdu = 0.
REQ-022 Reset SHALL override any simultaneous digit capture or sum.
REQ-023 Reset asserted mid-sequence, in any state, SHALL discard all partial operands; capture restarts at W1_C after deassertion.

Structure
REQ-024 A shared package sume_pkg SHALL hold the state enum type, DIGIT_MAX = 9, and W = 12 (output width).
REQ-025 The design SHALL instantiate one sub-module, sume_dec_acc, twice, once per operand.
REQ-026 sume_dec_acc SHALL be a 12-bit register with load-enable and synchronous clear, computing acc*10 + digit.
REQ-027 The FSM, the digit-valid check and the sum register SHALL reside in sume.

Verification
REQ-028 After reset, drive 1,2,3,4,5,6 on consecutive edges then 0 -> w1=123 (0x07B), w2=456 (0x1C8), cdu=579 (0x243) one edge after the 6 is captured.
REQ-029 Digits 9,9,9,9,9,9 -> w1=999, w2=999, cdu=1998 (0x7CE).
REQ-030 Digits 0,0,0,0,0,0 -> w1=w2=cdu=0, FSM reaches DONE.
REQ-031 Sequence 1,0xA,2,3,4,5,6 -> the 0xA cycle stalls in W1_D; final w1=123, w2=456, cdu=579, one clock later than REQ-028.
REQ-032 Digits 7,8, assert reset at the next edge, then 1..6 -> after the reset edge w1=0; final results 123, 456, 579.
REQ-033 In DONE, drive sample=9 for 5 clocks -> w1, w2 and cdu unchanged.
